// File: rtl/id_hazard_scheduler_pkg.sv
// Shared decode-stage definitions: shadow entry layout, scheduler states,
// register-file geometry and the busy-mask decode helper.
package id_hazard_scheduler_pkg;

    localparam int NUM_REGS = 8;
    localparam int REG_W    = 3;

    // One in-flight writer as seen from ID.
    typedef struct packed {
        logic             v;
        logic             we;
        logic [REG_W-1:0] rd;
    } shadow_entry_t;

    localparam shadow_entry_t SHADOW_BUBBLE = '{v: 1'b0, we: 1'b0, rd: {REG_W{1'b0}}};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    // One-hot destination of an entry, empty when the entry is not a live writer.
    function automatic logic [NUM_REGS-1:0] entry_mask(input shadow_entry_t e);
        logic [NUM_REGS-1:0] mask;
        mask = {NUM_REGS{1'b0}};
        if (e.v && e.we) begin
            mask[e.rd] = 1'b1;
        end else begin
            mask = {NUM_REGS{1'b0}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/id_hazard_scheduler_if.sv
// ID-stage issue bus between the decode/control logic and the scheduler.
interface id_hazard_scheduler_if
    import id_hazard_scheduler_pkg::*;
#(
    parameter int NUM_REGS = id_hazard_scheduler_pkg::NUM_REGS,
    parameter int REG_W    = id_hazard_scheduler_pkg::REG_W
);
    logic                id_valid;
    logic [REG_W-1:0]    id_rs;
    logic [REG_W-1:0]    id_rt;
    logic                id_reads_rs;
    logic                id_reads_rt;
    logic                id_wr_en;
    logic [REG_W-1:0]    id_wr_reg;
    logic                id_dump;
    logic                freeze;
    logic                flush;
    logic                stall_id;
    logic                issue;
    logic                halt;
    logic [NUM_REGS-1:0] busy_mask;

    modport master (
        output id_valid, id_rs, id_rt, id_reads_rs, id_reads_rt,
               id_wr_en, id_wr_reg, id_dump, freeze, flush,
        input  stall_id, issue, halt, busy_mask
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_reads_rs, id_reads_rt,
               id_wr_en, id_wr_reg, id_dump, freeze, flush,
        output stall_id, issue, halt, busy_mask
    );
endinterface

// File: rtl/id_hazard_scheduler_shadow_match.sv
// Compares one source specifier against one in-flight writer entry.
module shadow_match
    import id_hazard_scheduler_pkg::*;
(
    input  logic [REG_W-1:0] spec_i,
    input  shadow_entry_t    entry_i,
    output logic             hit_o
);
    assign hit_o = entry_i.v & entry_i.we & (entry_i.rd == spec_i);
endmodule

// File: rtl/id_hazard_scheduler.sv
// Decode-stage issue controller: RAW stall against the EX/MEM writers,
// three-deep writer shadow, and the dump/halt drain sequence.
module id_hazard_scheduler
    import id_hazard_scheduler_pkg::*;
#(
    parameter int NUM_REGS = id_hazard_scheduler_pkg::NUM_REGS,
    parameter int REG_W    = id_hazard_scheduler_pkg::REG_W
)(
    input  logic                  clk,
    input  logic                  rst,
    id_hazard_scheduler_if.slave  bus
);
    shadow_entry_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    state_e        state_q, state_d;

    logic hit_rs_ex_s, hit_rs_mem_s, hit_rt_ex_s, hit_rt_mem_s;
    logic haz_s, run_s, issue_s, stall_s;
    logic [NUM_REGS-1:0] busy_s;

    // WB is not searched: the register file forwards same-cycle writes.
    shadow_match u_rs_ex  (.spec_i(bus.id_rs), .entry_i(ex_q),  .hit_o(hit_rs_ex_s));
    shadow_match u_rs_mem (.spec_i(bus.id_rs), .entry_i(mem_q), .hit_o(hit_rs_mem_s));
    shadow_match u_rt_ex  (.spec_i(bus.id_rt), .entry_i(ex_q),  .hit_o(hit_rt_ex_s));
    shadow_match u_rt_mem (.spec_i(bus.id_rt), .entry_i(mem_q), .hit_o(hit_rt_mem_s));

    // Hazard detection and the combinational issue/stall decision.
    always_comb begin
        haz_s   = (bus.id_reads_rs & (hit_rs_ex_s | hit_rs_mem_s))
                | (bus.id_reads_rt & (hit_rt_ex_s | hit_rt_mem_s));
        run_s   = (state_q == ST_RUN);
        issue_s = bus.id_valid & ~haz_s & ~bus.freeze & ~bus.flush & run_s;
        // A flush redirects fetch, so a RAW stall is pointless then; freeze and
        // the drain states still hold ID because flush cannot override them.
        stall_s = ~run_s | bus.freeze | (bus.id_valid & haz_s & ~bus.flush);
    end

    // Shadow advance: the issued instruction or a bubble enters EX; freeze holds all.
    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (bus.freeze) begin
            ex_d  = ex_q;
            mem_d = mem_q;
            wb_d  = wb_q;
        end else begin
            if (issue_s) begin
                ex_d = '{v: 1'b1, we: bus.id_wr_en, rd: bus.id_wr_reg};
            end else begin
                ex_d = SHADOW_BUBBLE;
            end
            mem_d = ex_q;
            wb_d  = mem_q;
        end
    end

    // Scheduler next state: dump issue starts the drain, empty shadow ends it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (issue_s && bus.id_dump) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Nothing issues in DRAIN, so with EX and MEM empty the WB entry
                // retires on this edge and the shadow is empty afterwards.
                if (!bus.freeze && !ex_q.v && !mem_q.v) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Shadow and state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q    <= SHADOW_BUBBLE;
            mem_q   <= SHADOW_BUBBLE;
            wb_q    <= SHADOW_BUBBLE;
            state_q <= ST_RUN;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            state_q <= state_d;
        end
    end

    // Busy mask: destinations of every live writer in the shadow.
    always_comb begin
        busy_s = entry_mask(ex_q) | entry_mask(mem_q) | entry_mask(wb_q);
    end

    assign bus.issue     = issue_s;
    assign bus.stall_id  = stall_s;
    assign bus.halt      = (state_q == ST_HALT);
    assign bus.busy_mask = busy_s;

endmodule

// File: tb/tb_id_hazard_scheduler.sv
// Directed bench for id_hazard_scheduler with a scoreboard of expected outputs.
module tb_id_hazard_scheduler;

    logic clk;
    logic rst;

    id_hazard_scheduler_if bus ();

    id_hazard_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       issue;
        logic       stall;
        logic       halt;
        logic [7:0] busy;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic drive(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                         input logic rrs, input logic rrt, input logic we,
                         input logic [2:0] wr, input logic dump,
                         input logic frz, input logic fl);
        bus.id_valid    = v;
        bus.id_rs       = rs;
        bus.id_rt       = rt;
        bus.id_reads_rs = rrs;
        bus.id_reads_rt = rrt;
        bus.id_wr_en    = we;
        bus.id_wr_reg   = wr;
        bus.id_dump     = dump;
        bus.freeze      = frz;
        bus.flush       = fl;
    endtask

    task automatic expect_out(input string tag, input logic iss, input logic stl,
                              input logic hlt, input logic [7:0] busy);
        exp_t e;
        e.issue = iss;
        e.stall = stl;
        e.halt  = hlt;
        e.busy  = busy;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_pop();
        exp_t  e;
        string t;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries want 1");
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            assert (bus.issue === e.issue) else begin
                errors++;
                $display("FAIL %s issue: got %b want %b", t, bus.issue, e.issue);
                $error("issue check %s", t);
            end
            checks++;
            assert (bus.stall_id === e.stall) else begin
                errors++;
                $display("FAIL %s stall_id: got %b want %b", t, bus.stall_id, e.stall);
                $error("stall_id check %s", t);
            end
            checks++;
            assert (bus.halt === e.halt) else begin
                errors++;
                $display("FAIL %s halt: got %b want %b", t, bus.halt, e.halt);
                $error("halt check %s", t);
            end
            checks++;
            assert (bus.busy_mask === e.busy) else begin
                errors++;
                $display("FAIL %s busy_mask: got %h want %h", t, bus.busy_mask, e.busy);
                $error("busy_mask check %s", t);
            end
        end
    endtask

    // Called at posedge+1 with inputs driven: sample at negedge, then advance a cycle.
    task automatic settle();
        @(negedge clk);
        check_pop();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        #3;
        expect_out("reset", 1'b0, 1'b0, 1'b0, 8'h00);
        check_pop();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // RAW back-to-back on r3: two stall cycles, then issue from the WB bypass.
        drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        expect_out("raw_wr", 1'b1, 1'b0, 1'b0, 8'h00); settle();
        drive(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        expect_out("raw_s1", 1'b0, 1'b1, 1'b0, 8'h08); settle();
        expect_out("raw_s2", 1'b0, 1'b1, 1'b0, 8'h08); settle();
        expect_out("raw_go", 1'b1, 1'b0, 1'b0, 8'h08); settle();

        // Rt matches r3 in EX but is not really read: no stall.
        drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        expect_out("spur_wr", 1'b1, 1'b0, 1'b0, 8'h00); settle();
        drive(1'b1, 3'd1, 3'd3, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        expect_out("spur_rd", 1'b1, 1'b0, 1'b0, 8'h08); settle();

        // Reader against r3 sitting in MEM: one stall cycle, then WB bypass.
        drive(1'b1, 3'd0, 3'd3, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        expect_out("mem_rd", 1'b0, 1'b1, 1'b0, 8'h08); settle();
        expect_out("wb_byp", 1'b1, 1'b0, 1'b0, 8'h08); settle();

        // Freeze three cycles with r6 writer in EX: shadow holds.
        drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
        expect_out("fz_wr", 1'b1, 1'b0, 1'b0, 8'h00); settle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd6, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
            expect_out("fz_hold", 1'b0, 1'b1, 1'b0, 8'h40); settle();
        end
        drive(1'b1, 3'd6, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        expect_out("fz_rel", 1'b0, 1'b1, 1'b0, 8'h40); settle();
        expect_out("fz_s2", 1'b0, 1'b1, 1'b0, 8'h40); settle();
        expect_out("fz_go", 1'b1, 1'b0, 1'b0, 8'h40); settle();

        // Flush: non-hazard writer squashed, then flush over a hazard.
        drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        expect_out("fl_wr", 1'b1, 1'b0, 1'b0, 8'h00); settle();
        drive(1'b1, 3'd1, 3'd0, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1);
        expect_out("fl_noiss", 1'b0, 1'b0, 1'b0, 8'h04); settle();
        drive(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        expect_out("fl_haz", 1'b0, 1'b0, 1'b0, 8'h04); settle();
        drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        expect_out("fl_bub", 1'b0, 1'b0, 1'b0, 8'h04); settle();
        expect_out("fl_empty", 1'b0, 1'b0, 1'b0, 8'h00); settle();

        // Dump drain with an r5 write in flight; flush is ignored while draining.
        drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
        expect_out("d_wr5", 1'b1, 1'b0, 1'b0, 8'h00); settle();
        drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        expect_out("d_dump", 1'b1, 1'b0, 1'b0, 8'h20); settle();
        drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        expect_out("d_c1", 1'b0, 1'b1, 1'b0, 8'h20); settle();
        drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        expect_out("d_c2", 1'b0, 1'b1, 1'b0, 8'h20); settle();
        expect_out("d_c3", 1'b0, 1'b1, 1'b0, 8'h00); settle();
        drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1);
        expect_out("h_c1", 1'b0, 1'b1, 1'b1, 8'h00); settle();
        drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        expect_out("h_c2", 1'b0, 1'b1, 1'b1, 8'h00); settle();

        // Reset from HALT, then reset asserted mid-drain without a clock edge.
        rst = 1'b0;
        drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        expect_out("rst_halt", 1'b0, 1'b0, 1'b0, 8'h00);
        check_pop();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
        expect_out("r_wr7", 1'b1, 1'b0, 1'b0, 8'h00); settle();
        drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        expect_out("r_dump", 1'b1, 1'b0, 1'b0, 8'h80); settle();
        drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        expect_out("r_drain", 1'b0, 1'b1, 1'b0, 8'h80); settle();
        rst = 1'b0;
        #1;
        expect_out("rst_mid", 1'b0, 1'b0, 1'b0, 8'h00);
        check_pop();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
        expect_out("post_rst", 1'b1, 1'b0, 1'b0, 8'h00); settle();
        drive(1'b1, 3'd4, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        expect_out("post_raw", 1'b0, 1'b1, 1'b0, 8'h10); settle();

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $display("FAIL scoreboard_left: got %0d entries want 0", exp_q.size());
            $error("scoreboard not drained");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_hazard_scheduler.md
# id_hazard_scheduler

Issue controller for the decode stage. Each cycle it decides whether the instruction in ID may enter EX, based on whether the register-file reads it needs are safe. It keeps a three-entry shadow of in-flight writers (EX, MEM, WB) and stalls ID on read-after-write hazards that the write-before-read bypass in the register file cannot cover. It also sequences the halt drain for the dump instruction.

## Interface
Parameters:
- `NUM_REGS`, default 8: architectural register count; width of `busy_mask`.
- `REG_W`, default 3: register-specifier width.

Ports:
- `clk`  in  1  system clock. All state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset. It takes effect immediately while 0, independent of `clk`.
- `id_valid`  in  1  the IF/ID latch holds a real instruction.
- `id_rs`, `id_rt`  in  REG_W  source specifiers, instruction bits [10:8] and [7:5].
- `id_reads_rs`, `id_reads_rt`  in  1  from control: the instruction really reads Rs / Rt.
- `id_wr_en`  in  1  from control: the instruction writes a register.
- `id_wr_reg`  in  REG_W  resolved destination register.
- `id_dump`  in  1  the ID instruction is the halt/dump instruction.
- `freeze`  in  1  downstream (memory) stall. The whole pipeline holds.
- `flush`  in  1  EX resolved a taken branch or jump. The ID instruction is wrong-path.
- `stall_id`  out  1  hold the PC and the IF/ID latch.
- `issue`  out  1  the ID instruction enters EX at this clock edge.
- `halt`  out  1  sticky: the dump instruction has drained.
- `busy_mask`  out  NUM_REGS  bit r is set when any in-flight shadow entry writes register r.

## Operation
Shadow entry contents:
- Each entry holds {v, we, rd}.
- Entries: `ex`, `mem`, `wb`.

Hazard rule:
- `haz` = (`id_reads_rs` and Rs matches a valid, writing `ex` or `mem` entry) or (`id_reads_rt` and Rt matches a valid, writing `ex` or `mem` entry).
- The `wb` entry never causes a hazard, because the register file bypasses same-cycle writes.
- R0 is an ordinary register; there is no zero exemption.

Outputs:
- `issue` = `id_valid` & ~`haz` & ~`freeze` & ~`flush` & (state==RUN).
- `stall_id` = (`id_valid` & `haz`) | (state != RUN) | `freeze`.
  - `flush` overrides `stall_id`: the fetch unit redirects anyway.

Shadow advance, when `freeze` = 0:
- `ex` ← `issue` ? {1, `id_wr_en`, `id_wr_reg`} : bubble.
- `mem` ← `ex`.
- `wb` ← `mem`.

Shadow hold:
- When `freeze` = 1, all entries hold.
- `freeze` dominates `flush`: nothing changes and no issue occurs.

State machine:
- RUN:
  - `issue` & `id_dump` → DRAIN.
  - Otherwise stay in RUN.
- DRAIN:
  - No issue; `stall_id` = 1.
  - When `ex`, `mem` and `wb` are all invalid and `freeze` = 0 → HALT.
- HALT:
  - `halt` = 1 and `stall_id` = 1.
  - Leaves only on reset.
- `flush` in DRAIN or HALT has no effect: the dump instruction is older than the branch.

`busy_mask`: OR over the valid, writing `ex`/`mem`/`wb` entries of the one-hot decode of rd.

## Timing
- Reset (`rst` = 0), asynchronous:
  - state = RUN; all shadow v = 0.
  - `stall_id` = 0, `issue` = 0, `halt` = 0, `busy_mask` = 0.
- `issue`, `stall_id` and `haz` are combinational from inputs and state within the same cycle.
- `halt` and `busy_mask` are decoded from registers only.
- Minimum stall for back-to-back RAW: 2 cycles. The producer must reach WB.
- Stall on a reader in `mem` only: 1 cycle.
- Halt latency: `halt` rises 3 cycles after the dump issues, plus any `freeze` cycles.
- Simultaneous `flush` and hazard: no issue; a bubble is inserted; `stall_id` = 0.
- Reset asserted mid-DRAIN: returns to RUN immediately; the shadow is discarded.

## Structure
Shared pipeline package holds:
- the shadow-entry struct {v, we, rd};
- the state enum RUN / DRAIN / HALT;
- the `NUM_REGS` and `REG_W` constants.

Sub-module:
- `shadow_match`: compares one specifier against one entry and returns the hit.
- It is instantiated 4 times: {Rs, Rt} × {`ex`, `mem`}.
- The FSM and shadow registers live in the top module.

## Test plan
- RAW back-to-back: issue writer r3, then a reader of Rs = r3 with `id_reads_rs` = 1.
  - Required: `stall_id` = 1 for 2 cycles, then `issue` = 1.
  - `busy_mask` = 0x08 while r3 is in flight.
- Spurious reads ignored: reader with Rt = r3 but `id_reads_rt` = 0.
  - Required: no stall.
- WB bypass: producer reaches `wb` while the reader is in ID.
  - Required: `issue` = 1 with no stall.
- Freeze: assert `freeze` for 3 cycles with the writer in `ex`.
  - Required: shadow unchanged, `issue` = 0.
  - After release, the reader issues 2 cycles later.
- Flush: assert `flush` with a valid non-hazard instruction in ID.
  - Required: `issue` = 0.
  - The next cycle `ex`.v = 0 and `busy_mask` drops the bit.
- Dump drain: issue dump with r5 writes still in flight.
  - Required: `halt` rises 3 cycles after the dump issues and stays 1.
- Reset mid-drain: pull `rst` low mid-drain.
  - Required: `halt` = 0, `busy_mask` = 0 and RUN, immediately and without a clock edge.
